// File: rtl/cnt_sched_pkg.sv
// Shared types and defaults for the cnt_sched command scheduler and its counter.
// The optional div3 tracking is enabled with CNT_SCHED_DIV3_EN.
package cnt_sched_pkg;

   localparam int W_DEF         = 16;
   localparam int LIMIT_RST_DEF = 300;

   typedef enum logic [1:0] {
      CMD_STOP      = 2'd0,
      CMD_START     = 2'd1,
      CMD_LOAD      = 2'd2,
      CMD_SET_LIMIT = 2'd3
   } cmd_e;

   typedef enum logic {
      ST_HOLD = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   function automatic logic [1:0] mod3_inc(input logic [1:0] r);
      return (r == 2'd2) ? 2'd0 : r + 2'd1;
   endfunction

endpackage

// File: rtl/cnt_sched_if.sv
// Two-requester command channel: per-requester valid/cmd/data, shared ready and grant id.
interface cnt_sched_if
   import cnt_sched_pkg::*;
#(
   parameter int W = W_DEF
) ();

   logic [1:0]   req_valid;
   logic [1:0]   req_ready;
   cmd_e         req0_cmd;
   cmd_e         req1_cmd;
   logic [W-1:0] req0_data;
   logic [W-1:0] req1_data;
   logic         grant_id;

   modport master (
      output req_valid, req0_cmd, req1_cmd, req0_data, req1_data,
      input  req_ready, grant_id
   );

   modport slave (
      input  req_valid, req0_cmd, req1_cmd, req0_data, req1_data,
      output req_ready, grant_id
   );

endinterface

// File: rtl/cnt_sched_mod3.sv
// mod3_tracker: residue-mod-3 shadow of the event counter, producing a registered div3 flag.
// Only instantiated when CNT_SCHED_DIV3_EN is defined.
module mod3_tracker
   import cnt_sched_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         inc,
   input  logic         clr,
   output logic         div3
);

   logic [1:0] residue;
   logic [1:0] load_res;

   // Reduce the load operand MSB-first: r' = (2r + bit) mod 3, which stays in 0..5 before the fold.
   always_comb begin
      logic [2:0] tmp;
      load_res = 2'd0;
      tmp      = 3'd0;
      for (int i = W - 1; i >= 0; i--) begin
         tmp      = {load_res, load_data[i]};
         load_res = (tmp >= 3'd3) ? 2'(tmp - 3'd3) : tmp[1:0];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         residue <= 2'd0;
      end else if (load) begin
         residue <= load_res;
      end else if (clr) begin
         residue <= 2'd0;
      end else if (inc) begin
         residue <= mod3_inc(residue);
      end
   end

   assign div3 = (residue == 2'd0);

endmodule

// File: rtl/cnt_sched.sv
// cnt_sched: round-robin command scheduler owning the shared wrap-around event counter.
// Define CNT_SCHED_DIV3_EN to build the residue tracker that drives div3; otherwise div3 is 0.
module cnt_sched
   import cnt_sched_pkg::*;
#(
   parameter int W         = W_DEF,
   parameter int LIMIT_RST = LIMIT_RST_DEF
) (
   input  logic         clk,
   input  logic         rstn,
   cnt_sched_if.slave   bus,
   output logic [W-1:0] cnt,
   output logic         running,
   output logic         wrap,
   output logic         div3
);

   logic         prio;
   logic         accept;
   logic         gid;
   cmd_e         sel_cmd;
   logic [W-1:0] sel_data;
   logic [W-1:0] limit;
   state_e       state;
   logic         step;
   logic         step_wrap;

   // Preferred requester wins if valid, else the other one; nothing is accepted while in reset.
   always_comb begin
      accept = 1'b0;
      gid    = prio;
      if (rstn) begin
         if (bus.req_valid[prio]) begin
            accept = 1'b1;
         end else if (bus.req_valid[~prio]) begin
            accept = 1'b1;
            gid    = ~prio;
         end
      end
   end

   assign bus.req_ready = accept ? (gid ? 2'b10 : 2'b01) : 2'b00;
   assign bus.grant_id  = gid;
   assign sel_cmd       = gid ? bus.req1_cmd  : bus.req0_cmd;
   assign sel_data      = gid ? bus.req1_data : bus.req0_data;

   assign step      = !accept && (state == ST_RUN);
   assign step_wrap = step && (cnt >= limit);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= ST_RUN;
      end else if (accept) begin
         case (sel_cmd)
            CMD_STOP:      state <= ST_HOLD;
            CMD_START:     state <= ST_RUN;
            CMD_LOAD:      state <= state;
            CMD_SET_LIMIT: state <= state;
            default:       state <= state;
         endcase
      end
   end

   assign running = (state == ST_RUN);

   // Accepted commands take precedence over the count step, so load and increment never coincide.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt   <= '0;
         limit <= W'(LIMIT_RST);
         wrap  <= 1'b0;
         prio  <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (accept) begin
            prio <= ~gid;
            if (sel_cmd == CMD_LOAD) begin
               cnt <= sel_data;
            end
            if (sel_cmd == CMD_SET_LIMIT) begin
               limit <= sel_data;
            end
         end else if (step_wrap) begin
            cnt  <= '0;
            wrap <= 1'b1;
         end else if (step) begin
            cnt <= cnt + W'(1);
         end
      end
   end

`ifdef CNT_SCHED_DIV3_EN
   logic load_en;
   assign load_en = accept && (sel_cmd == CMD_LOAD);

   mod3_tracker #(
      .W (W)
   ) u_mod3 (
      .clk       (clk),
      .rstn      (rstn),
      .load      (load_en),
      .load_data (sel_data),
      .inc       (step && !step_wrap),
      .clr       (step_wrap),
      .div3      (div3)
   );
`else
   assign div3 = 1'b0;
`endif

endmodule

// File: tb/tb_cnt_sched.sv
// Directed testbench for cnt_sched: a vector table for arbitration and command effects,
// plus hand-written sequences for free-run wrap, SET_LIMIT below count, STOP/START and async reset.
module tb_cnt_sched;
   import cnt_sched_pkg::*;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rstn;
   logic [W-1:0] cnt;
   logic         running;
   logic         wrap;
   logic         div3;

   int n_vec  = 0;
   int n_fail = 0;

   cnt_sched_if #(.W(W)) bus ();

   cnt_sched #(
      .W         (W),
      .LIMIT_RST (300)
   ) dut (
      .clk     (clk),
      .rstn    (rstn),
      .bus     (bus),
      .cnt     (cnt),
      .running (running),
      .wrap    (wrap),
      .div3    (div3)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   valid;
      cmd_e         c0;
      logic [W-1:0] d0;
      cmd_e         c1;
      logic [W-1:0] d1;
      logic [1:0]   ready;
      logic         gid;
      int           cnt;
      logic         run;
      logic         wrap;
   } vec_t;

   vec_t tbl[$];

   function automatic logic exp_div3(input int c);
      logic en;
`ifdef CNT_SCHED_DIV3_EN
      en = 1'b1;
`else
      en = 1'b0;
`endif
      return en && ((c % 3) == 0);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [1:0] valid, input cmd_e c0, input logic [W-1:0] d0,
                                 input cmd_e c1, input logic [W-1:0] d1);
      bus.req_valid = valid;
      bus.req0_cmd  = c0;
      bus.req0_data = d0;
      bus.req1_cmd  = c1;
      bus.req1_data = d1;
   endtask

   task automatic check_ready(input string tag, input logic [1:0] exp_ready, input logic exp_gid);
      check({tag, " ready"}, 32'(bus.req_ready), 32'(exp_ready));
      if (exp_ready != 2'b00) check({tag, " grant_id"}, 32'(bus.grant_id), 32'(exp_gid));
   endtask

   task automatic check_output(input string tag, input int exp_cnt, input logic exp_run, input logic exp_wrap);
      check({tag, " cnt"}, 32'(cnt), 32'(exp_cnt));
      check({tag, " running"}, 32'(running), 32'(exp_run));
      check({tag, " wrap"}, 32'(wrap), 32'(exp_wrap));
      check({tag, " div3"}, 32'(div3), 32'(exp_div3(exp_cnt)));
   endtask

   // One clock of stimulus: check combinational handshake before the edge, registers after it.
   task automatic run_cycle(input string tag, input logic [1:0] valid, input cmd_e c0, input logic [W-1:0] d0,
                            input cmd_e c1, input logic [W-1:0] d1, input logic [1:0] exp_ready,
                            input logic exp_gid, input int exp_cnt, input logic exp_run, input logic exp_wrap);
      apply_stimulus(valid, c0, d0, c1, d1);
      #1;
      check_ready(tag, exp_ready, exp_gid);
      @(posedge clk);
      #1;
      check_output(tag, exp_cnt, exp_run, exp_wrap);
   endtask

   task automatic idle_cycle(input string tag, input int exp_cnt, input logic exp_run, input logic exp_wrap);
      run_cycle(tag, 2'b00, CMD_STOP, '0, CMD_STOP, '0, 2'b00, 1'b0, exp_cnt, exp_run, exp_wrap);
   endtask

   task automatic do_reset(input string tag);
      apply_stimulus(2'b00, CMD_STOP, '0, CMD_STOP, '0);
      rstn = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rstn = 1'b1;
      #1;
      check_ready(tag, 2'b00, 1'b0);
      check_output(tag, 0, 1'b1, 1'b0);
   endtask

   initial begin
      rstn = 1'b0;
      apply_stimulus(2'b00, CMD_STOP, '0, CMD_STOP, '0);

      //                valid  c0             d0     c1          d1   ready  gid  cnt  run  wrap
      tbl.push_back('{2'b11, CMD_STOP,      16'd0,   CMD_STOP,  16'd0, 2'b01, 1'b0, 0,   1'b0, 1'b0});
      tbl.push_back('{2'b11, CMD_STOP,      16'd0,   CMD_STOP,  16'd0, 2'b10, 1'b1, 0,   1'b0, 1'b0});
      tbl.push_back('{2'b11, CMD_STOP,      16'd0,   CMD_STOP,  16'd0, 2'b01, 1'b0, 0,   1'b0, 1'b0});
      tbl.push_back('{2'b00, CMD_STOP,      16'd0,   CMD_STOP,  16'd0, 2'b00, 1'b0, 0,   1'b0, 1'b0});
      tbl.push_back('{2'b01, CMD_LOAD,      16'd299, CMD_STOP,  16'd0, 2'b01, 1'b0, 299, 1'b0, 1'b0});
      tbl.push_back('{2'b10, CMD_STOP,      16'd0,   CMD_START, 16'd0, 2'b10, 1'b1, 299, 1'b1, 1'b0});
      tbl.push_back('{2'b00, CMD_STOP,      16'd0,   CMD_STOP,  16'd0, 2'b00, 1'b0, 300, 1'b1, 1'b0});
      tbl.push_back('{2'b00, CMD_STOP,      16'd0,   CMD_STOP,  16'd0, 2'b00, 1'b0, 0,   1'b1, 1'b1});
      tbl.push_back('{2'b00, CMD_STOP,      16'd0,   CMD_STOP,  16'd0, 2'b00, 1'b0, 1,   1'b1, 1'b0});
      tbl.push_back('{2'b11, CMD_SET_LIMIT, 16'd2,   CMD_LOAD,  16'd5, 2'b01, 1'b0, 1,   1'b1, 1'b0});
      tbl.push_back('{2'b10, CMD_STOP,      16'd0,   CMD_LOAD,  16'd5, 2'b10, 1'b1, 5,   1'b1, 1'b0});
      tbl.push_back('{2'b00, CMD_STOP,      16'd0,   CMD_STOP,  16'd0, 2'b00, 1'b0, 0,   1'b1, 1'b1});
      tbl.push_back('{2'b00, CMD_STOP,      16'd0,   CMD_STOP,  16'd0, 2'b00, 1'b0, 1,   1'b1, 1'b0});
      tbl.push_back('{2'b00, CMD_STOP,      16'd0,   CMD_STOP,  16'd0, 2'b00, 1'b0, 2,   1'b1, 1'b0});
      tbl.push_back('{2'b00, CMD_STOP,      16'd0,   CMD_STOP,  16'd0, 2'b00, 1'b0, 0,   1'b1, 1'b1});
      tbl.push_back('{2'b01, CMD_SET_LIMIT, 16'd0,   CMD_STOP,  16'd0, 2'b01, 1'b0, 0,   1'b1, 1'b0});
      tbl.push_back('{2'b00, CMD_STOP,      16'd0,   CMD_STOP,  16'd0, 2'b00, 1'b0, 0,   1'b1, 1'b1});
      tbl.push_back('{2'b00, CMD_STOP,      16'd0,   CMD_STOP,  16'd0, 2'b00, 1'b0, 0,   1'b1, 1'b1});
      tbl.push_back('{2'b10, CMD_STOP,      16'd0,   CMD_STOP,  16'd0, 2'b10, 1'b1, 0,   1'b0, 1'b0});
      tbl.push_back('{2'b00, CMD_STOP,      16'd0,   CMD_STOP,  16'd0, 2'b00, 1'b0, 0,   1'b0, 1'b0});
      tbl.push_back('{2'b11, CMD_START,     16'd0,   CMD_START, 16'd0, 2'b01, 1'b0, 0,   1'b1, 1'b0});
      tbl.push_back('{2'b10, CMD_STOP,      16'd0,   CMD_START, 16'd0, 2'b10, 1'b1, 0,   1'b1, 1'b0});
      tbl.push_back('{2'b01, CMD_LOAD,      16'd0,   CMD_STOP,  16'd0, 2'b01, 1'b0, 0,   1'b1, 1'b0});
      tbl.push_back('{2'b01, CMD_SET_LIMIT, 16'd300, CMD_STOP,  16'd0, 2'b01, 1'b0, 0,   1'b1, 1'b0});
      tbl.push_back('{2'b00, CMD_STOP,      16'd0,   CMD_STOP,  16'd0, 2'b00, 1'b0, 1,   1'b1, 1'b0});
      tbl.push_back('{2'b01, CMD_STOP,      16'd0,   CMD_STOP,  16'd0, 2'b01, 1'b0, 1,   1'b0, 1'b0});
      tbl.push_back('{2'b10, CMD_STOP,      16'd0,   CMD_STOP,  16'd0, 2'b10, 1'b1, 1,   1'b0, 1'b0});
      tbl.push_back('{2'b00, CMD_STOP,      16'd0,   CMD_STOP,  16'd0, 2'b00, 1'b0, 1,   1'b0, 1'b0});

      do_reset("reset0");
      foreach (tbl[i]) begin
         run_cycle($sformatf("vec%0d", i), tbl[i].valid, tbl[i].c0, tbl[i].d0, tbl[i].c1, tbl[i].d1,
                   tbl[i].ready, tbl[i].gid, tbl[i].cnt, tbl[i].run, tbl[i].wrap);
      end

      // Free-run with the reset limit: 0..300, then a single wrap cycle at 0.
      do_reset("reset1");
      for (int i = 1; i <= 300; i++) idle_cycle($sformatf("free%0d", i), i, 1'b1, 1'b0);
      idle_cycle("free_wrap", 0, 1'b1, 1'b1);
      idle_cycle("free_after", 1, 1'b1, 1'b0);

      // SET_LIMIT 5 while cnt = 10 wraps on the next step, then runs 0..5.
      do_reset("reset2");
      for (int i = 1; i <= 10; i++) idle_cycle($sformatf("pre_lim%0d", i), i, 1'b1, 1'b0);
      run_cycle("setlim5", 2'b01, CMD_SET_LIMIT, 16'd5, CMD_STOP, '0, 2'b01, 1'b0, 10, 1'b1, 1'b0);
      idle_cycle("lim_wrap", 0, 1'b1, 1'b1);
      for (int i = 1; i <= 5; i++) idle_cycle($sformatf("lim%0d", i), i, 1'b1, 1'b0);
      idle_cycle("lim_wrap2", 0, 1'b1, 1'b1);

      // STOP at 7, hold, START, then counting resumes.
      do_reset("reset3");
      for (int i = 1; i <= 7; i++) idle_cycle($sformatf("pre_stop%0d", i), i, 1'b1, 1'b0);
      run_cycle("stop7", 2'b01, CMD_STOP, '0, CMD_STOP, '0, 2'b01, 1'b0, 7, 1'b0, 1'b0);
      for (int i = 1; i <= 4; i++) idle_cycle($sformatf("hold%0d", i), 7, 1'b0, 1'b0);
      run_cycle("start", 2'b01, CMD_START, '0, CMD_STOP, '0, 2'b01, 1'b0, 7, 1'b1, 1'b0);
      idle_cycle("resume", 8, 1'b1, 1'b0);

      // Async reset with req1 holding a LOAD: state clears at once and nothing is accepted.
      apply_stimulus(2'b10, CMD_STOP, '0, CMD_LOAD, 16'd100);
      #1;
      check_ready("pre_rst", 2'b10, 1'b1);
      rstn = 1'b0;
      #1;
      check_ready("in_rst", 2'b00, 1'b0);
      check_output("in_rst", 0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      check_output("in_rst_edge", 0, 1'b1, 1'b0);
      rstn = 1'b1;
      #1;
      check_ready("post_rst", 2'b10, 1'b1);
      @(posedge clk);
      #1;
      check_output("post_rst_load", 100, 1'b1, 1'b0);
      idle_cycle("post_rst_step", 101, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
